// File: rtl/ram_mem_dp_pkg.sv
// ram_mem_dp_pkg
//   Shared definitions for the dual-port RAM and its clear sequencer:
//   clear-FSM state encoding and the read-during-write mode selectors.
package ram_mem_dp_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

endpackage

// File: rtl/ram_mem_dp_clr_seq.sv
// ram_mem_dp_clr_seq
//   Clear sequencer: walks every address once, issuing a write strobe per
//   cycle, then returns to IDLE. Starts after reset (CLR_ON_RST) or on clr_i.
// Ports
//   clk_i      clock
//   rst_n_i    asynchronous active-low reset
//   clr_i      start request, honoured only in IDLE
//   busy_o     sweep in progress
//   clr_we_o   sweep write strobe
//   clr_addr_o sweep write address
module ram_mem_dp_clr_seq
  import ram_mem_dp_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int CLR_ON_RST = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  clr_i,
  output logic                  busy_o,
  output logic                  clr_we_o,
  output logic [ADDR_WIDTH-1:0] clr_addr_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  clr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= (CLR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Counter wraps back to 0 as the last word is written.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ADDR) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == ST_CLEAR);
    clr_we_o   = (state_q == ST_CLEAR);
    clr_addr_o = cnt_q;
  end

endmodule

// File: rtl/ram_mem_dp.sv
// ram_mem_dp
//   Simple dual-port synchronous RAM (one write port, one read port, one
//   clock) with byte-lane write enables, selectable read-during-write
//   behaviour, optional output register and a hardware clear sweep.
// Ports
//   CLK       clock, posedge
//   RST_N     asynchronous active-low reset
//   WE        write request           W_ADDR   write address
//   BYTE_EN   per-lane write enable   DATA_IN  write data
//   RE        read request            R_ADDR   read address
//   DATA_OUT  read data               VALID    1-cycle read-data strobe
//   CLR       start clear sweep       BUSY     sweep in progress, ports ignored
module ram_mem_dp
  import ram_mem_dp_pkg::*;
#(
  parameter int               ADDR_WIDTH = 4,
  parameter int               WIDTH      = 8,
  parameter int               BYTE_W     = 8,
  parameter int               RDW_MODE   = RDW_READ_FIRST,
  parameter int               OUT_REG    = 0,
  parameter int               CLR_ON_RST = 1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0,
  localparam int              NB         = WIDTH / BYTE_W
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  WE,
  input  logic [ADDR_WIDTH-1:0] W_ADDR,
  input  logic [NB-1:0]         BYTE_EN,
  input  logic [WIDTH-1:0]      DATA_IN,
  input  logic                  RE,
  input  logic [ADDR_WIDTH-1:0] R_ADDR,
  output logic [WIDTH-1:0]      DATA_OUT,
  output logic                  VALID,
  input  logic                  CLR,
  output logic                  BUSY
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  function automatic logic [WIDTH-1:0] lane_merge(input logic [WIDTH-1:0] old_w,
                                                  input logic [WIDTH-1:0] new_w,
                                                  input logic [NB-1:0]    be);
    logic [WIDTH-1:0] res;
    res = old_w;
    for (int i = 0; i < NB; i++) begin
      if (be[i]) res[i*BYTE_W +: BYTE_W] = new_w[i*BYTE_W +: BYTE_W];
    end
    return res;
  endfunction

  logic                  clr_we;
  logic [ADDR_WIDTH-1:0] clr_addr;

  ram_mem_dp_clr_seq #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .CLR_ON_RST (CLR_ON_RST)
  ) u_clr_seq (
    .clk_i      (CLK),
    .rst_n_i    (RST_N),
    .clr_i      (CLR),
    .busy_o     (BUSY),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  logic [WIDTH-1:0] mem_q [DEPTH];

  // A CLR request in IDLE wins over any user access in the same cycle.
  logic             accept_d, user_we_d, user_re_d, bypass_d;
  logic [WIDTH-1:0] wr_word_d, rd_word_d;

  always_comb begin
    accept_d  = !BUSY && !CLR;
    user_we_d = accept_d && WE;
    user_re_d = accept_d && RE;
    wr_word_d = lane_merge(mem_q[W_ADDR], DATA_IN, BYTE_EN);
    bypass_d  = (RDW_MODE == RDW_WRITE_FIRST) && user_we_d && (W_ADDR == R_ADDR);
    rd_word_d = bypass_d ? lane_merge(mem_q[R_ADDR], DATA_IN, BYTE_EN) : mem_q[R_ADDR];
  end

  // Array contents are deliberately not reset; the clear sweep initialises them.
  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem_q[clr_addr] <= INIT_VALUE;
    end else if (user_we_d) begin
      mem_q[W_ADDR] <= wr_word_d;
    end
  end

  // ---- stage p1: array read register ----
  logic [WIDTH-1:0] rd_data_p1_q;
  logic             vld_p1_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_data_p1_q <= '0;
      vld_p1_q     <= 1'b0;
    end else begin
      vld_p1_q <= user_re_d;
      if (user_re_d) rd_data_p1_q <= rd_word_d;
    end
  end

  // ---- stage p2: optional output register ----
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [WIDTH-1:0] rd_data_p2_q;
      logic             vld_p2_q;

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          rd_data_p2_q <= '0;
          vld_p2_q     <= 1'b0;
        end else begin
          vld_p2_q <= vld_p1_q;
          if (vld_p1_q) rd_data_p2_q <= rd_data_p1_q;
        end
      end

      assign DATA_OUT = rd_data_p2_q;
      assign VALID    = vld_p2_q;
    end else begin : g_no_out_reg
      assign DATA_OUT = rd_data_p1_q;
      assign VALID    = vld_p1_q;
    end
  endgenerate

endmodule

// File: tb/tb_ram_mem_dp.sv
// tb_ram_mem_dp
//   Two instances driven with identical stimulus:
//     dut0: WIDTH=16, read-first, no output register, clear on reset, INIT 0x0000
//     dut1: WIDTH=16, write-first, output register, no clear on reset, INIT 0x00A5
//   A memory-array / pending-read-queue model predicts BUSY, VALID and DATA_OUT.
module tb_ram_mem_dp;

  localparam int AW    = 4;
  localparam int W     = 16;
  localparam int NB    = 2;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, we, re, clr;
  logic [AW-1:0] wa, ra;
  logic [NB-1:0] be;
  logic [W-1:0]  di;
  logic [W-1:0]  dout0, dout1;
  logic          v0, v1, b0, b1;

  ram_mem_dp #(
    .ADDR_WIDTH (AW), .WIDTH (W), .BYTE_W (8), .RDW_MODE (0), .OUT_REG (0),
    .CLR_ON_RST (1), .INIT_VALUE (16'h0000)
  ) dut0 (
    .CLK (clk), .RST_N (rst_n), .WE (we), .W_ADDR (wa), .BYTE_EN (be), .DATA_IN (di),
    .RE (re), .R_ADDR (ra), .DATA_OUT (dout0), .VALID (v0), .CLR (clr), .BUSY (b0)
  );

  ram_mem_dp #(
    .ADDR_WIDTH (AW), .WIDTH (W), .BYTE_W (8), .RDW_MODE (1), .OUT_REG (1),
    .CLR_ON_RST (0), .INIT_VALUE (16'h00A5)
  ) dut1 (
    .CLK (clk), .RST_N (rst_n), .WE (we), .W_ADDR (wa), .BYTE_EN (be), .DATA_IN (di),
    .RE (re), .R_ADDR (ra), .DATA_OUT (dout1), .VALID (v1), .CLR (clr), .BUSY (b1)
  );

  logic [W-1:0] act_dout [2];
  logic         act_valid[2];
  logic         act_busy [2];
  always_comb begin
    act_dout[0] = dout0;  act_dout[1] = dout1;
    act_valid[0] = v0;    act_valid[1] = v1;
    act_busy[0] = b0;     act_busy[1] = b1;
  end

  // ---------------- reference model ----------------
  int           m_rdw[2], m_lat[2], m_clr_rst[2];
  logic [W-1:0] m_init[2];
  logic [W-1:0] m_mem[2][DEPTH];
  int           sweep_left[2], sweep_addr[2];
  logic [W-1:0] exp_dout[2];
  logic         exp_valid[2], exp_busy[2];
  int           cyc;

  typedef struct { int dut; int due; logic [W-1:0] dat; } rd_t;
  rd_t pend[$];

  int n_cmp, n_bad;

  function automatic logic [W-1:0] merge(input logic [W-1:0] o, input logic [W-1:0] n,
                                         input logic [NB-1:0] b);
    logic [W-1:0] m;
    m = {{8{b[1]}}, {8{b[0]}}};
    return (o & ~m) | (n & m);
  endfunction

  task automatic drive(input logic we_v, input int wa_v, input logic [NB-1:0] be_v,
                       input logic [W-1:0] di_v, input logic re_v, input int ra_v,
                       input logic clr_v);
    we = we_v; wa = AW'(wa_v); be = be_v; di = di_v;
    re = re_v; ra = AW'(ra_v); clr = clr_v;
  endtask

  // One clock: update model with the inputs the DUTs sample, then settle.
  task automatic step();
    @(posedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (sweep_left[d] > 0) begin
        m_mem[d][sweep_addr[d]] = m_init[d];
        sweep_addr[d]++;
        sweep_left[d]--;
      end else if (clr) begin
        sweep_left[d] = DEPTH;
        sweep_addr[d] = 0;
      end else begin
        if (re) begin
          logic [W-1:0] rd;
          rd = m_mem[d][ra];
          if (m_rdw[d] == 1 && we && wa == ra) rd = merge(rd, di, be);
          pend.push_back('{d, cyc + m_lat[d] - 1, rd});
        end
        if (we) m_mem[d][wa] = merge(m_mem[d][wa], di, be);
      end
      exp_valid[d] = 1'b0;
      for (int i = 0; i < pend.size(); i++) begin
        if (pend[i].dut == d && pend[i].due == cyc) begin
          exp_valid[d] = 1'b1;
          exp_dout[d]  = pend[i].dat;
        end
      end
      exp_busy[d] = (sweep_left[d] > 0);
    end
    for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due <= cyc) pend.delete(i);
    #1;
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      exp_dout[d]   = '0;
      exp_valid[d]  = 1'b0;
      sweep_left[d] = (m_clr_rst[d] != 0) ? DEPTH : 0;
      sweep_addr[d] = 0;
      exp_busy[d]   = (sweep_left[d] > 0);
    end
    pend.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int busy_cycles;
    drive(0, 0, 2'b00, '0, 0, 0, 0);
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (dout0 !== 16'h0000 || v0 !== 1'b0 || b0 !== 1'b1 || b1 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got dout0=%h v0=%b b0=%b b1=%b want 0000 0 1 0", dout0, v0, b0, b1);
    end
    rst_n = 1'b1;
    busy_cycles = 0;
    for (int k = 0; k < 20; k++) begin
      if (b0) busy_cycles++;
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (act_busy[d] !== exp_busy[d]) begin n_bad++; $display("FAIL reset_busy dut%0d t=%0t: got %b want %b", d, $time, act_busy[d], exp_busy[d]); end
      end
    end
    n_cmp++;
    if (busy_cycles != 16) begin n_bad++; $display("FAIL sweep_len: got %0d cycles want 16", busy_cycles); end
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 0, 2'b00, '0, 1, a, 0);
      step();
      n_cmp++;
      if (v0 !== 1'b1 || dout0 !== 16'h0000) begin n_bad++; $display("FAIL cleared_read @%0d: got v=%b d=%h want 1 0000", a, v0, dout0); end
    end
    drive(0, 0, 2'b00, '0, 0, 0, 0);
    step();
  endtask

  task automatic test_clear_init();
    // Writes, then CLR together with a write @7 which must be dropped.
    for (int a = 0; a < 4; a++) begin
      drive(1, a + 6, 2'b11, 16'h1111 * (a + 1), 0, 0, 0);
      step();
    end
    drive(1, 7, 2'b11, 16'hDEAD, 0, 0, 1);
    step();
    for (int k = 0; k < 16; k++) begin
      drive(1, k, 2'b11, 16'hBEEF, 1, k, 0);
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (act_busy[d] !== exp_busy[d]) begin n_bad++; $display("FAIL clr_busy dut%0d t=%0t: got %b want %b", d, $time, act_busy[d], exp_busy[d]); end
        n_cmp++;
        if (act_valid[d] !== exp_valid[d]) begin n_bad++; $display("FAIL clr_valid dut%0d t=%0t: got %b want %b", d, $time, act_valid[d], exp_valid[d]); end
      end
    end
    for (int a = 0; a < DEPTH + 1; a++) begin
      drive(0, 0, 2'b00, '0, a < DEPTH, a % DEPTH, 0);
      step();
      if (a < DEPTH) begin
        n_cmp++;
        if (dout0 !== 16'h0000) begin n_bad++; $display("FAIL init0 @%0d: got %h want 0000", a, dout0); end
      end
      if (a > 0) begin
        n_cmp++;
        if (v1 !== 1'b1 || dout1 !== 16'h00A5) begin n_bad++; $display("FAIL init1 @%0d: got v=%b d=%h want 1 00a5", a - 1, v1, dout1); end
      end
    end
    drive(0, 0, 2'b00, '0, 0, 0, 0);
    step();
  endtask

  task automatic test_byte_lanes();
    drive(1, 3, 2'b11, 16'hABCD, 0, 0, 0); step();
    drive(1, 3, 2'b10, 16'h12FF, 0, 0, 0); step();
    drive(1, 3, 2'b00, 16'hFFFF, 0, 0, 0); step();
    drive(0, 0, 2'b00, '0, 1, 3, 0);       step();
    n_cmp++;
    if (v0 !== 1'b1 || dout0 !== 16'h12CD) begin n_bad++; $display("FAIL lanes dut0: got v=%b d=%h want 1 12cd", v0, dout0); end
    n_cmp++;
    if (v1 !== 1'b0) begin n_bad++; $display("FAIL lanes_lat dut1: got v=%b want 0", v1); end
    drive(0, 0, 2'b00, '0, 0, 0, 0);       step();
    n_cmp++;
    if (v1 !== 1'b1 || dout1 !== 16'h12CD) begin n_bad++; $display("FAIL lanes dut1: got v=%b d=%h want 1 12cd", v1, dout1); end
    n_cmp++;
    if (v0 !== 1'b0 || dout0 !== 16'h12CD) begin n_bad++; $display("FAIL hold dut0: got v=%b d=%h want 0 12cd", v0, dout0); end
  endtask

  task automatic test_rdw();
    drive(1, 5, 2'b11, 16'h0011, 0, 0, 0); step();
    drive(1, 5, 2'b11, 16'h0022, 1, 5, 0); step();
    n_cmp++;
    if (v0 !== 1'b1 || dout0 !== 16'h0011) begin n_bad++; $display("FAIL rdw_read_first: got v=%b d=%h want 1 0011", v0, dout0); end
    drive(0, 0, 2'b00, '0, 1, 5, 0);       step();
    n_cmp++;
    if (v1 !== 1'b1 || dout1 !== 16'h0022) begin n_bad++; $display("FAIL rdw_write_first: got v=%b d=%h want 1 0022", v1, dout1); end
    n_cmp++;
    if (v0 !== 1'b1 || dout0 !== 16'h0022) begin n_bad++; $display("FAIL rdw_after0: got v=%b d=%h want 1 0022", v0, dout0); end
    drive(0, 0, 2'b00, '0, 0, 0, 0);       step();
    n_cmp++;
    if (v1 !== 1'b1 || dout1 !== 16'h0022) begin n_bad++; $display("FAIL rdw_after1: got v=%b d=%h want 1 0022", v1, dout1); end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] want1 [5];
    logic         wantv [5];
    for (int a = 1; a <= 3; a++) begin
      drive(1, a, 2'b11, 16'h0101 * a, 0, 0, 0);
      step();
    end
    want1 = '{16'h0000, 16'h0101, 16'h0202, 16'h0303, 16'h0303};
    wantv = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 2'b00, '0, k < 3, k + 1, 0);
      step();
      n_cmp++;
      if (v1 !== wantv[k] || (wantv[k] && dout1 !== want1[k])) begin
        n_bad++; $display("FAIL b2b dut1 k=%0d: got v=%b d=%h want v=%b d=%h", k, v1, dout1, wantv[k], want1[k]);
      end
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (act_valid[d] !== exp_valid[d] || act_dout[d] !== exp_dout[d]) begin
          n_bad++; $display("FAIL b2b_model dut%0d k=%0d: got v=%b d=%h want v=%b d=%h", d, k, act_valid[d], act_dout[d], exp_valid[d], exp_dout[d]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    int busy_cycles;
    drive(1, 2, 2'b11, 16'h5A5A, 0, 0, 0); step();
    drive(0, 0, 2'b00, '0, 1, 2, 0);       step();
    drive(0, 0, 2'b00, '0, 0, 0, 1);       step();
    drive(0, 0, 2'b00, '0, 0, 0, 0);
    for (int k = 0; k < 5; k++) step();
    n_cmp++;
    if (dout0 !== 16'h5A5A || b0 !== 1'b1) begin n_bad++; $display("FAIL pre_reset: got d=%h busy=%b want 5a5a 1", dout0, b0); end
    rst_n = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (dout0 !== 16'h0000 || v0 !== 1'b0 || dout1 !== 16'h0000 || v1 !== 1'b0) begin
      n_bad++; $display("FAIL async_reset: got d0=%h v0=%b d1=%h v1=%b want 0", dout0, v0, dout1, v1);
    end
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    busy_cycles = 0;
    for (int k = 0; k < 18; k++) begin
      if (b0) busy_cycles++;
      drive(1, $urandom_range(0, 15), 2'($urandom_range(0, 3)), W'($urandom), 0, 0, 0);
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (act_busy[d] !== exp_busy[d]) begin n_bad++; $display("FAIL restart_busy dut%0d t=%0t: got %b want %b", d, $time, act_busy[d], exp_busy[d]); end
      end
    end
    n_cmp++;
    if (busy_cycles != 16) begin n_bad++; $display("FAIL restart_len: got %0d cycles want 16", busy_cycles); end
  endtask

  task automatic test_random();
    int a;
    for (int k = 0; k < 500; k++) begin
      a = $urandom_range(0, 15);
      drive($urandom_range(0, 1) == 1, a, 2'($urandom_range(0, 3)), W'($urandom),
            $urandom_range(0, 2) != 0, ($urandom_range(0, 2) == 0) ? a : $urandom_range(0, 15),
            $urandom_range(0, 79) == 0);
      step();
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (act_busy[d] !== exp_busy[d]) begin n_bad++; $display("FAIL rnd_busy dut%0d t=%0t: got %b want %b", d, $time, act_busy[d], exp_busy[d]); end
        n_cmp++;
        if (act_valid[d] !== exp_valid[d]) begin n_bad++; $display("FAIL rnd_valid dut%0d t=%0t: got %b want %b", d, $time, act_valid[d], exp_valid[d]); end
        if (!$isunknown(exp_dout[d])) begin
          n_cmp++;
          if (act_dout[d] !== exp_dout[d]) begin n_bad++; $display("FAIL rnd_dout dut%0d t=%0t: got %h want %h", d, $time, act_dout[d], exp_dout[d]); end
        end
      end
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    m_rdw     = '{0, 1};
    m_lat     = '{1, 2};
    m_clr_rst = '{1, 0};
    m_init    = '{16'h0000, 16'h00A5};
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < DEPTH; a++) m_mem[d][a] = 'x;
    rst_n = 1'b0;
    drive(0, 0, 2'b00, '0, 0, 0, 0);
    #1;
    test_reset();
    test_clear_init();
    test_byte_lanes();
    test_rdw();
    test_back_to_back();
    test_reset_mid_sweep();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
